// File: rtl/interrupt_controller.sv
// Priority interrupt controller: edge-detects NSRC lines into PEND, gates them with MASK,
// and runs a single-level REQ/ack/EOI handshake with the CPU.
module interrupt_controller #(
    parameter int unsigned NSRC = 8,
    parameter int unsigned IDW  = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [NSRC-1:0]  irq,
    input  logic             sel,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             intr,
    input  logic             inta
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t          state;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic            cause_valid;
    logic [IDW-1:0]  cause_id;

    logic [NSRC-1:0] edge_det;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] ack_clr;
    logic [IDW-1:0]  winner;
    logic            found;
    logic            ack;
    logic            wr_pend;
    logic            wr_mask;
    logic            wr_eoi;

    assign edge_det = irq & ~irq_q;
    assign active   = pend & mask;
    assign wr_pend  = sel && we && (addr == 2'd0);
    assign wr_mask  = sel && we && (addr == 2'd1);
    assign wr_eoi   = sel && we && (addr == 2'd3);
    assign ack      = (state == REQ) && inta;

    // Lowest index wins; scanning upward and keeping the first hit.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (active[i] && !found) begin
                winner = IDW'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        w1c     = '0;
        ack_clr = '0;
        if (wr_pend)
            w1c = wdata[NSRC-1:0];
        if (ack)
            ack_clr[winner] = 1'b1;
    end

    generate
        if (NSRC < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^wdata[31:NSRC];
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                2'd0: rdata[NSRC-1:0] = pend;
                2'd1: rdata[NSRC-1:0] = mask;
                2'd2: begin
                    rdata[31]      = cause_valid;
                    rdata[IDW-1:0] = cause_id;
                end
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        irq_q <= irq;
        if (clr) begin
            state       <= IDLE;
            intr        <= 1'b0;
            pend        <= '0;
            mask        <= '0;
            cause_valid <= 1'b0;
            cause_id    <= '0;
        end else begin
            // New edges are OR'd in last so a set always beats a same-cycle clear.
            pend <= (pend & ~(w1c | ack_clr)) | edge_det;
            if (wr_mask)
                mask <= wdata[NSRC-1:0];
            case (state)
                IDLE: begin
                    if (active != '0) begin
                        state <= REQ;
                        intr  <= 1'b1;
                    end
                end
                REQ: begin
                    if (inta) begin
                        cause_valid <= 1'b1;
                        cause_id    <= winner;
                        state       <= SERV;
                        intr        <= 1'b0;
                    end else if (active == '0) begin
                        state <= IDLE;
                        intr  <= 1'b0;
                    end
                end
                SERV: begin
                    if (wr_eoi) begin
                        cause_valid <= 1'b0;
                        cause_id    <= '0;
                        state       <= IDLE;
                        intr        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    intr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: expected values are queued as stimulus
// is applied and popped when the corresponding register or intr value is observed.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  irq;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        intr;
    logic        inta;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp;

    interrupt_controller #(.NSRC(8), .IDW(3)) dut (
        .clk   (clk),
        .clr   (clr),
        .irq   (irq),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .intr  (intr),
        .inta  (inta)
    );

    always #5 clk = ~clk;

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        cycle(1);
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] v);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        v = rdata;
        sel = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq = v;
        cycle(1);
        irq = '0;
    endtask

    task automatic pulse_inta();
        inta = 1'b1;
        cycle(1);
        inta = 1'b0;
    endtask

    task automatic test_reset();
        irq = 8'h01; clr = 1'b1;
        cycle(2);
        clr = 1'b0;
        exp_q.push_back(32'h0);
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_intr got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h0);
        sel = 1'b0; addr = 2'd1; #1;
        got = rdata; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_rdata_unsel got=%h exp=%h", got, exp); end
        do_write(2'd1, 32'hFF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        cycle(3);
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_no_edge_pend got=%h exp=%h", got, exp); end
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_no_edge_intr got=%h exp=%h", got, exp); end
        irq = '0;
        cycle(1);
    endtask

    task automatic test_single();
        pulse_irq(8'h08);
        exp_q.push_back(32'h08);
        exp_q.push_back(32'h0);
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL single_pend got=%h exp=%h", got, exp); end
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL single_intr_early got=%h exp=%h", got, exp); end
        cycle(1);
        exp_q.push_back(32'h1);
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL single_intr got=%h exp=%h", got, exp); end
        pulse_inta();
        exp_q.push_back(32'h80000003);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        do_read(2'd2, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL single_cause got=%h exp=%h", got, exp); end
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL single_pend_ack got=%h exp=%h", got, exp); end
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL single_intr_ack got=%h exp=%h", got, exp); end
        do_write(2'd3, 32'h1);
        exp_q.push_back(32'h0);
        do_read(2'd2, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL single_cause_eoi got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h0);
        do_read(2'd3, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL eoi_read got=%h exp=%h", got, exp); end
    endtask

    task automatic test_priority();
        pulse_irq(8'h24);
        cycle(1);
        pulse_inta();
        exp_q.push_back(32'h80000002);
        exp_q.push_back(32'h20);
        do_read(2'd2, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL prio_cause_first got=%h exp=%h", got, exp); end
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL prio_pend_first got=%h exp=%h", got, exp); end
        do_write(2'd3, 32'h0);
        exp_q.push_back(32'h0);
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL prio_intr_after_eoi got=%h exp=%h", got, exp); end
        cycle(1);
        exp_q.push_back(32'h1);
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL prio_intr_reassert got=%h exp=%h", got, exp); end
        pulse_inta();
        exp_q.push_back(32'h80000005);
        exp_q.push_back(32'h0);
        do_read(2'd2, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL prio_cause_second got=%h exp=%h", got, exp); end
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL prio_pend_second got=%h exp=%h", got, exp); end
        do_write(2'd3, 32'h0);
    endtask

    task automatic test_mask_w1c();
        do_write(2'd1, 32'h00);
        pulse_irq(8'h02);
        cycle(3);
        exp_q.push_back(32'h02);
        exp_q.push_back(32'h0);
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mask_pend got=%h exp=%h", got, exp); end
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mask_intr_masked got=%h exp=%h", got, exp); end
        pulse_inta();
        exp_q.push_back(32'h0);
        do_read(2'd2, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL inta_idle_ignored got=%h exp=%h", got, exp); end
        do_write(2'd1, 32'h02);
        exp_q.push_back(32'h02);
        do_read(2'd1, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mask_readback got=%h exp=%h", got, exp); end
        cycle(1);
        exp_q.push_back(32'h1);
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mask_intr_rise got=%h exp=%h", got, exp); end
        do_write(2'd0, 32'h02);
        exp_q.push_back(32'h0);
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL w1c_pend got=%h exp=%h", got, exp); end
        cycle(1);
        exp_q.push_back(32'h0);
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL w1c_intr_drop got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        do_write(2'd1, 32'hFF);
        pulse_irq(8'h10);
        cycle(1);
        irq = 8'h10; inta = 1'b1;
        cycle(1);
        irq = '0; inta = 1'b0;
        exp_q.push_back(32'h80000004);
        exp_q.push_back(32'h10);
        do_read(2'd2, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_cause got=%h exp=%h", got, exp); end
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_pend_kept got=%h exp=%h", got, exp); end
        do_write(2'd3, 32'h0);
        cycle(1);
        pulse_inta();
        exp_q.push_back(32'h80000004);
        exp_q.push_back(32'h0);
        do_read(2'd2, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_cause_again got=%h exp=%h", got, exp); end
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_pend_clear got=%h exp=%h", got, exp); end
        do_write(2'd3, 32'h0);
    endtask

    task automatic test_reset_in_serv();
        pulse_irq(8'h04);
        cycle(1);
        pulse_inta();
        pulse_irq(8'h0C);
        exp_q.push_back(32'h0C);
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL serv_pend_accum got=%h exp=%h", got, exp); end
        clr = 1'b1;
        cycle(1);
        clr = 1'b0;
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(32'h0);
            do_read(a[1:0], got); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL clr_reg%0d got=%h exp=%h", a, got, exp); end
        end
        exp_q.push_back(32'h0);
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL clr_intr got=%h exp=%h", got, exp); end
        do_write(2'd3, 32'h0);
        pulse_inta();
        cycle(2);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        do_read(2'd2, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL clr_quiet_cause got=%h exp=%h", got, exp); end
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL clr_quiet_intr got=%h exp=%h", got, exp); end
        pulse_irq(8'h01);
        exp_q.push_back(32'h01);
        do_read(2'd0, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL clr_new_edge got=%h exp=%h", got, exp); end
        do_write(2'd1, 32'h01);
        cycle(1);
        exp_q.push_back(32'h1);
        got = {31'b0, intr}; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL clr_new_intr got=%h exp=%h", got, exp); end
    endtask

    initial begin
        clr = 1'b1; irq = '0; sel = 1'b0; addr = '0; we = 1'b0; wdata = '0; inta = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_mask_w1c();
        test_back_to_back();
        test_reset_in_serv();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Priority interrupt controller that sits directly upstream of the single-cycle CPU with interrupts. It collects up to NSRC external interrupt lines, edge-detects and latches them as pending, and drives the CPU's `intr` request. It consumes the CPU's `inta` acknowledge and exposes pending, mask, cause and end-of-interrupt registers on the CPU data-memory bus. Nesting is not supported: one interrupt is in service at a time.

## Interface
Parameters:
- NSRC, default 8: number of interrupt sources; 2..32.
- IDW, default 3: width of the source id; equals clog2(NSRC).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- irq  in  NSRC  interrupt source lines; level inputs, synchronous to clk.
- sel  in  1  register-block select, decoded from the CPU data address.
- addr  in  2  word select, CPU address bits [3:2].
- we  in  1  write strobe; qualified by sel.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational from addr; 0 when sel=0.
- intr  out  1  interrupt request to the CPU.
- inta  in  1  interrupt acknowledge from the CPU; a one-cycle pulse.

## Operation
Registers, selected by addr:
- 0 PEND: bit i set = source i pending. Read-only. Writing 1 to a bit clears it.
- 1 MASK: bit i = 1 enables source i. Read/write. Reset value 0, so all sources are masked.
- 2 CAUSE: bit31 = valid; bits[IDW-1:0] = id of the last acknowledged source. Read-only.
- 3 EOI: write-only; any write ends service. Reads return 0.

Edge detection:
- irq_q holds irq from the previous cycle.
- pend[i] sets on irq[i] & ~irq_q[i].
- During clr, irq_q loads irq, so a line already high at reset produces no edge.

Flags:
- active = pend & MASK.
- winner = lowest-index set bit of active. Index 0 has the highest priority.

State machine (state reset value IDLE):
- IDLE: if active ≠ 0, go to REQ.
- REQ: intr = 1.
  - If inta = 1: CAUSE <= {1, winner}, clear pend[winner], go to SERV.
  - Else, if active = 0 (the source was masked or cleared by software), go to IDLE.
- SERV: intr = 0.
  - A write to EOI clears CAUSE.valid and goes to IDLE.
  - Pending bits keep accumulating in SERV.
- inta outside REQ is ignored.

Simultaneous events:
- Set beats clear on the same bit. This covers a W1C to PEND or an ack clear in the same cycle as a new edge on that bit; pend stays 1.
- An ack in REQ uses the winner computed from the pre-edge register values.
- A MASK write and an ack in the same cycle: the ack uses the old MASK.
- An EOI write outside SERV has no effect.

Reset mid-operation:
- clr in any state forces IDLE.
- pend = 0, MASK = 0, CAUSE = 0, intr = 0.

## Timing
- intr is a registered function of state: intr = (state == REQ).
- Reset values: intr = 0; rdata = 0 when sel = 0.
- Latency from irq rising before edge k, with the source enabled:
  - pend set after edge k.
  - state REQ and intr = 1 after edge k+1.
- Ack sampled at edge m: intr = 0 and CAUSE valid after edge m; pend bit cleared after edge m.
- EOI written at edge n: state IDLE after edge n. If another source is active, intr is high again after edge n+1.
- intr never drops in REQ without either an ack or active going to 0.

## Test plan
- Reset with irq = 0x01 held high, then MASK = 0xFF: no edge is detected, so PEND = 0 and intr stays 0.
- MASK = 0xFF, pulse irq[3] for 1 cycle: PEND = 0x08 after 1 cycle; intr = 1 one cycle later. Pulse inta: CAUSE = 0x80000003, PEND = 0, intr = 0. Write EOI: CAUSE = 0.
- Pulse irq[5] and irq[2] in the same cycle, MASK = 0xFF: ack gives CAUSE id 2 and PEND = 0x20. After EOI, intr reasserts; the second ack gives id 5.
- MASK = 0x00, pulse irq[1]: PEND = 0x02 and intr stays 0. Write MASK = 0x02: intr rises 1 cycle later. Write PEND = 0x02 while in REQ: PEND = 0, state returns to IDLE, intr = 0.
- In REQ with irq[4] pending, an irq[4] edge coincides with the inta ack: CAUSE id 4 and PEND bit 4 remains 1.
- clr asserted in SERV with PEND = 0x0C: the next cycle reads all registers 0 and intr = 0. EOI writes and inta pulses then do nothing until a new edge arrives.
